// File: rtl/csi2_packet_rx.sv
// CSI-2 packet receiver: merges lane bytes, parses the packet header, filters by VC and packs payload into words.
// Optional payload CRC-16 check is compiled in when CSI2_PACKET_RX_CRC_CHECK_EN is defined.
module csi2_packet_rx #(
  parameter int         NUM_LANES = 2,
  parameter logic [3:0] VC_MASK   = 4'b1111
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [8*NUM_LANES-1:0] lane_data,
  input  logic                   lane_valid,
  output logic [1:0]             virtual_channel,
  output logic [5:0]             data_type,
  output logic [15:0]            word_count,
  output logic                   header_valid,
  output logic [31:0]            image_data,
  output logic [3:0]             image_data_keep,
  output logic                   image_data_enable,
  output logic                   packet_done,
  output logic                   packet_abort,
  output logic                   crc_error,
  output logic                   busy
);

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CRC
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  hdr_idx_reg, hdr_idx_next;
  logic [7:0]  hdr_b0_reg, hdr_b0_next;
  logic [7:0]  hdr_b1_reg, hdr_b1_next;
  logic [7:0]  hdr_b2_reg, hdr_b2_next;
  logic [15:0] pkt_wc_reg, pkt_wc_next;
  logic        accept_reg, accept_next;
  logic [15:0] byte_cnt_reg, byte_cnt_next;
  logic [31:0] acc_reg, acc_next;
  logic [1:0]  acc_cnt_reg, acc_cnt_next;
  logic        crc_idx_reg, crc_idx_next;

  logic [1:0]  vc_reg, vc_next;
  logic [5:0]  dt_reg, dt_next;
  logic [15:0] word_count_reg, word_count_next;
  logic        header_valid_reg, header_valid_next;
  logic [31:0] image_data_reg, image_data_next;
  logic [3:0]  keep_reg, keep_next;
  logic        enable_reg, enable_next;
  logic        done_reg, done_next;
  logic        abort_reg, abort_next;
  logic        busy_reg, busy_next;

  logic [7:0]  cur;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_dt;
  logic        pkt_ok;

`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
  logic [7:0]  crc_lo_reg, crc_lo_next;
  logic [15:0] crc_calc_reg, crc_calc_next;
  logic        crc_error_reg, crc_error_next;

  // Reflected CRC-16 (0x8408), one byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction
`endif

  logic [7:0] lane_byte [NUM_LANES];

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_byte[gi] = lane_data[8*gi +: 8];
  end

  // Bytes of one cycle are walked in lane order so a cycle may cross state boundaries.
  always_comb begin
    state_next        = state_reg;
    hdr_idx_next      = hdr_idx_reg;
    hdr_b0_next       = hdr_b0_reg;
    hdr_b1_next       = hdr_b1_reg;
    hdr_b2_next       = hdr_b2_reg;
    pkt_wc_next       = pkt_wc_reg;
    accept_next       = accept_reg;
    byte_cnt_next     = byte_cnt_reg;
    acc_next          = acc_reg;
    acc_cnt_next      = acc_cnt_reg;
    crc_idx_next      = crc_idx_reg;
    vc_next           = vc_reg;
    dt_next           = dt_reg;
    word_count_next   = word_count_reg;
    header_valid_next = 1'b0;
    image_data_next   = image_data_reg;
    keep_next         = keep_reg;
    enable_next       = 1'b0;
    done_next         = 1'b0;
    abort_next        = 1'b0;
    cur               = 8'h00;
    pkt_vc            = 2'd0;
    pkt_dt            = 6'd0;
    pkt_ok            = 1'b0;
`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
    crc_lo_next       = crc_lo_reg;
    crc_calc_next     = crc_calc_reg;
    crc_error_next    = 1'b0;
`endif

    if (!lane_valid) begin
      // A filtered packet stays silent even when it is cut short.
      if (state_reg == ST_HEADER) begin
        abort_next = 1'b1;
      end else if (state_reg == ST_PAYLOAD || state_reg == ST_CRC) begin
        abort_next = accept_reg;
      end
      state_next = ST_IDLE;
    end else begin
      if (state_reg == ST_IDLE) begin
        state_next   = ST_HEADER;
        hdr_idx_next = 2'd0;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        cur = lane_byte[i];
        case (state_next)
          ST_HEADER: begin
            case (hdr_idx_next)
              2'd0: hdr_b0_next = cur;
              2'd1: hdr_b1_next = cur;
              2'd2: hdr_b2_next = cur;
              default: begin
                pkt_vc        = hdr_b0_next[7:6];
                pkt_dt        = hdr_b0_next[5:0];
                pkt_wc_next   = {hdr_b2_next, hdr_b1_next};
                pkt_ok        = VC_MASK[pkt_vc];
                accept_next   = pkt_ok;
                byte_cnt_next = 16'd0;
                acc_next      = 32'd0;
                acc_cnt_next  = 2'd0;
                crc_idx_next  = 1'b0;
`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
                crc_calc_next = 16'hFFFF;
`endif
                if (pkt_ok) begin
                  vc_next           = pkt_vc;
                  dt_next           = pkt_dt;
                  word_count_next   = pkt_wc_next;
                  header_valid_next = 1'b1;
                end
                if (pkt_dt <= 6'h0F) begin
                  done_next  = pkt_ok;
                  state_next = ST_DRAIN;
                end else if (pkt_wc_next == 16'd0) begin
                  state_next = ST_CRC;
                end else begin
                  state_next = ST_PAYLOAD;
                end
              end
            endcase
            hdr_idx_next = hdr_idx_next + 2'd1;
          end
          ST_PAYLOAD: begin
            acc_next[8*acc_cnt_next +: 8] = cur;
            byte_cnt_next = byte_cnt_next + 16'd1;
`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
            crc_calc_next = crc16_byte(crc_calc_next, cur);
`endif
            if (acc_cnt_next == 2'd3 || byte_cnt_next == pkt_wc_next) begin
              if (accept_next) begin
                image_data_next = acc_next;
                enable_next     = 1'b1;
                case (acc_cnt_next)
                  2'd0:    keep_next = 4'b0001;
                  2'd1:    keep_next = 4'b0011;
                  2'd2:    keep_next = 4'b0111;
                  default: keep_next = 4'b1111;
                endcase
              end
              acc_next     = 32'd0;
              acc_cnt_next = 2'd0;
            end else begin
              acc_cnt_next = acc_cnt_next + 2'd1;
            end
            if (byte_cnt_next == pkt_wc_next) begin
              state_next = ST_CRC;
            end
          end
          ST_CRC: begin
            if (crc_idx_next == 1'b0) begin
`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
              crc_lo_next = cur;
`endif
              crc_idx_next = 1'b1;
            end else begin
              done_next  = accept_next;
`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
              crc_error_next = accept_next && (crc_calc_next != {cur, crc_lo_next});
`endif
              state_next = ST_DRAIN;
            end
          end
          default: ;
        endcase
      end
    end

    busy_next = (state_next == ST_HEADER) || (state_next == ST_PAYLOAD) || (state_next == ST_CRC);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_DRAIN;
      hdr_idx_reg      <= 2'd0;
      hdr_b0_reg       <= 8'h00;
      hdr_b1_reg       <= 8'h00;
      hdr_b2_reg       <= 8'h00;
      pkt_wc_reg       <= 16'd0;
      accept_reg       <= 1'b0;
      byte_cnt_reg     <= 16'd0;
      acc_reg          <= 32'd0;
      acc_cnt_reg      <= 2'd0;
      crc_idx_reg      <= 1'b0;
      vc_reg           <= 2'd0;
      dt_reg           <= 6'd0;
      word_count_reg   <= 16'd0;
      header_valid_reg <= 1'b0;
      image_data_reg   <= 32'd0;
      keep_reg         <= 4'd0;
      enable_reg       <= 1'b0;
      done_reg         <= 1'b0;
      abort_reg        <= 1'b0;
      busy_reg         <= 1'b0;
`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
      crc_lo_reg       <= 8'h00;
      crc_calc_reg     <= 16'hFFFF;
      crc_error_reg    <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      hdr_idx_reg      <= hdr_idx_next;
      hdr_b0_reg       <= hdr_b0_next;
      hdr_b1_reg       <= hdr_b1_next;
      hdr_b2_reg       <= hdr_b2_next;
      pkt_wc_reg       <= pkt_wc_next;
      accept_reg       <= accept_next;
      byte_cnt_reg     <= byte_cnt_next;
      acc_reg          <= acc_next;
      acc_cnt_reg      <= acc_cnt_next;
      crc_idx_reg      <= crc_idx_next;
      vc_reg           <= vc_next;
      dt_reg           <= dt_next;
      word_count_reg   <= word_count_next;
      header_valid_reg <= header_valid_next;
      image_data_reg   <= image_data_next;
      keep_reg         <= keep_next;
      enable_reg       <= enable_next;
      done_reg         <= done_next;
      abort_reg        <= abort_next;
      busy_reg         <= busy_next;
`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
      crc_lo_reg       <= crc_lo_next;
      crc_calc_reg     <= crc_calc_next;
      crc_error_reg    <= crc_error_next;
`endif
    end
  end

  assign virtual_channel   = vc_reg;
  assign data_type         = dt_reg;
  assign word_count        = word_count_reg;
  assign header_valid      = header_valid_reg;
  assign image_data        = image_data_reg;
  assign image_data_keep   = keep_reg;
  assign image_data_enable = enable_reg;
  assign packet_done       = done_reg;
  assign packet_abort      = abort_reg;
  assign busy              = busy_reg;
`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
  assign crc_error         = crc_error_reg;
`else
  assign crc_error         = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_packet_rx.sv
// Bench for csi2_packet_rx: 1/2/4-lane instances, scoreboard queues filled from the byte-level packet model.
`timescale 1ns/1ps
module tb_csi2_packet_rx;

  typedef struct packed {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        done;
  } hdr_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        done;
  } word_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n;
  logic [7:0]  ld1;
  logic [15:0] ld2;
  logic [31:0] ld4;
  logic        lv1, lv2, lv4;

  logic [1:0]  vc1, vc2, vc4;
  logic [5:0]  dt1, dt2, dt4;
  logic [15:0] wc1, wc2, wc4;
  logic        hv1, hv2, hv4;
  logic [31:0] id1, id2, id4;
  logic [3:0]  ik1, ik2, ik4;
  logic        ie1, ie2, ie4, pd1, pd2, pd4, pa1, pa2, pa4, ce1, ce2, ce4, bz1, bz2, bz4;

  csi2_packet_rx #(.NUM_LANES(1), .VC_MASK(4'b1111)) dut1 (
    .clock(clock), .reset_n(rst_n), .lane_data(ld1), .lane_valid(lv1),
    .virtual_channel(vc1), .data_type(dt1), .word_count(wc1), .header_valid(hv1),
    .image_data(id1), .image_data_keep(ik1), .image_data_enable(ie1),
    .packet_done(pd1), .packet_abort(pa1), .crc_error(ce1), .busy(bz1));

  csi2_packet_rx #(.NUM_LANES(2), .VC_MASK(4'b0001)) dut2 (
    .clock(clock), .reset_n(rst_n), .lane_data(ld2), .lane_valid(lv2),
    .virtual_channel(vc2), .data_type(dt2), .word_count(wc2), .header_valid(hv2),
    .image_data(id2), .image_data_keep(ik2), .image_data_enable(ie2),
    .packet_done(pd2), .packet_abort(pa2), .crc_error(ce2), .busy(bz2));

  csi2_packet_rx #(.NUM_LANES(4), .VC_MASK(4'b1111)) dut4 (
    .clock(clock), .reset_n(rst_n), .lane_data(ld4), .lane_valid(lv4),
    .virtual_channel(vc4), .data_type(dt4), .word_count(wc4), .header_valid(hv4),
    .image_data(id4), .image_data_keep(ik4), .image_data_enable(ie4),
    .packet_done(pd4), .packet_abort(pa4), .crc_error(ce4), .busy(bz4));

  int total = 0;
  int bad = 0;
  int abort_exp = 0;
  int abort_seen = 0;
  int sel = 1;

  logic [7:0] tx_q[$];
  hdr_t       hq[$];
  word_t      wq[$];
  logic       dq[$];

  logic [1:0]  m_vc;
  logic [5:0]  m_dt;
  logic [15:0] m_wc;
  logic [31:0] m_id;
  logic [3:0]  m_ik;
  logic        m_hv, m_ie, m_pd, m_pa, m_ce, m_bz;

  always_comb begin
    case (sel)
      1: {m_vc, m_dt, m_wc, m_hv, m_id, m_ik, m_ie, m_pd, m_pa, m_ce, m_bz} =
           {vc1, dt1, wc1, hv1, id1, ik1, ie1, pd1, pa1, ce1, bz1};
      2: {m_vc, m_dt, m_wc, m_hv, m_id, m_ik, m_ie, m_pd, m_pa, m_ce, m_bz} =
           {vc2, dt2, wc2, hv2, id2, ik2, ie2, pd2, pa2, ce2, bz2};
      default: {m_vc, m_dt, m_wc, m_hv, m_id, m_ik, m_ie, m_pd, m_pa, m_ce, m_bz} =
           {vc4, dt4, wc4, hv4, id4, ik4, ie4, pd4, pa4, ce4, bz4};
    endcase
  end

  // Scoreboard monitor: every output pulse pops and checks the oldest expectation.
  always @(negedge clock) begin
    hdr_t  h;
    word_t w;
    logic  e;
    if (m_hv) begin
      total++;
      if (hq.size() == 0) begin
        bad++;
        $display("FAIL header_unexpected got vc=%0d dt=%h wc=%h", m_vc, m_dt, m_wc);
      end else begin
        h = hq.pop_front();
        if (m_vc !== h.vc || m_dt !== h.dt || m_wc !== h.wc || m_pd !== h.done) begin
          bad++;
          $display("FAIL header got vc=%0d dt=%h wc=%h done=%b need vc=%0d dt=%h wc=%h done=%b",
                   m_vc, m_dt, m_wc, m_pd, h.vc, h.dt, h.wc, h.done);
        end else
          $display("header ok lanes=%0d vc=%0d dt=%h wc=%h", sel, m_vc, m_dt, m_wc);
      end
    end
    if (m_ie) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL word_unexpected got data=%h keep=%h", m_id, m_ik);
      end else begin
        w = wq.pop_front();
        if (m_id !== w.data || m_ik !== w.keep || m_pd !== w.done) begin
          bad++;
          $display("FAIL word got data=%h keep=%h done=%b need data=%h keep=%h done=%b",
                   m_id, m_ik, m_pd, w.data, w.keep, w.done);
        end else
          $display("word ok lanes=%0d data=%h keep=%h", sel, m_id, m_ik);
      end
    end
    if (m_pd) begin
      total++;
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected got crc_error=%b", m_ce);
      end else begin
        e = dq.pop_front();
        if (m_ce !== e) begin
          bad++;
          $display("FAIL done_crc got crc_error=%b need %b", m_ce, e);
        end else
          $display("done ok lanes=%0d crc_error=%b", sel, m_ce);
      end
    end
    if (m_pa) begin
      abort_seen++;
      $display("abort seen lanes=%0d", sel);
    end
  end

  function automatic logic [15:0] crc_model(input int start, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, tx_q[start+i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // Byte-level packet model: expected header, words and done for the burst in tx_q.
  task automatic expect_packet(input int nl, input bit accepted);
    hdr_t h;
    word_t w;
    int wc;
    if (!accepted) return;
    h.vc = tx_q[0][7:6];
    h.dt = tx_q[0][5:0];
    h.wc = {tx_q[2], tx_q[1]};
    h.done = (h.dt <= 6'h0F);
    wc = int'(h.wc);
    hq.push_back(h);
    if (h.done) begin
      dq.push_back(1'b0);
      return;
    end
    for (int i = 0; i < wc; i += 4) begin
      w.data = '0;
      w.keep = '0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < wc) begin
          w.data[8*j +: 8] = tx_q[4+i+j];
          w.keep[j] = 1'b1;
        end
      end
      w.done = (i + 4 >= wc) && ((3 + wc) / nl == (5 + wc) / nl);
      wq.push_back(w);
    end
`ifdef CSI2_PACKET_RX_CRC_CHECK_EN
    dq.push_back(crc_model(4, wc) != {tx_q[5+wc], tx_q[4+wc]});
`else
    dq.push_back(1'b0);
`endif
  endtask

  task automatic put(input int nl, input logic [31:0] w, input logic v);
    case (nl)
      1: begin ld1 = w[7:0]; lv1 = v; end
      2: begin ld2 = w[15:0]; lv2 = v; end
      default: begin ld4 = w; lv4 = v; end
    endcase
  endtask

  task automatic drive_burst(input int nl, input int nsend, input int gap);
    logic [31:0] w;
    for (int k = 0; k < nsend; k += nl) begin
      w = '0;
      for (int l = 0; l < nl; l++) if (k + l < nsend) w[8*l +: 8] = tx_q[k+l];
      @(posedge clock); #1;
      put(nl, w, 1'b1);
    end
    @(posedge clock); #1;
    put(nl, 32'h0, 1'b0);
    repeat (gap) @(posedge clock);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int s = 1; s <= 4; s = s * 2) begin
      sel = s;
      #1;
      total++;
      if ({m_vc, m_dt, m_wc, m_hv, m_id, m_ik, m_ie, m_pd, m_pa, m_ce, m_bz} !== '0) begin
        bad++;
        $display("FAIL reset_state lanes=%0d got %h need 0", s,
                 {m_vc, m_dt, m_wc, m_hv, m_id, m_ik, m_ie, m_pd, m_pa, m_ce, m_bz});
      end else
        $display("reset ok lanes=%0d", s);
    end
    @(posedge clock); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_short_packet();
    sel = 2;
    tx_q = '{8'h08, 8'hCE, 8'hFA, 8'h12};
    expect_packet(2, 1'b1);
    drive_burst(2, tx_q.size(), 4);
    total++;
    if (hq.size() + wq.size() + dq.size() != 0) begin
      bad++;
      $display("FAIL short_pending got %0d need 0", hq.size() + wq.size() + dq.size());
    end
  endtask

  task automatic test_long_packet();
    sel = 2;
    tx_q = '{8'h18, 8'h08, 8'h00, 8'hFE, 8'hAD, 8'hDE, 8'hE1, 8'hFE,
             8'h5E, 8'hEA, 8'h15, 8'h0D, 8'hD0, 8'hF0};
    expect_packet(2, 1'b1);
    drive_burst(2, tx_q.size(), 4);
    total++;
    if (hq.size() + wq.size() + dq.size() != 0) begin
      bad++;
      $display("FAIL long_pending got %0d need 0", hq.size() + wq.size() + dq.size());
    end
  endtask

  task automatic test_crc_vector();
    sel = 1;
    tx_q = '{8'h18, 8'h18, 8'h00, 8'h00,
             8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
             8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01,
             8'hF0, 8'h00};
    expect_packet(1, 1'b1);
    void'(dq.pop_back());
    dq.push_back(1'b0);
    drive_burst(1, tx_q.size(), 4);
    total++;
    if (hq.size() + wq.size() + dq.size() != 0) begin
      bad++;
      $display("FAIL crc_vector_pending got %0d need 0", hq.size() + wq.size() + dq.size());
    end
  endtask

  task automatic test_four_lane();
    logic [15:0] c;
    sel = 4;
    tx_q = '{8'h18, 8'h06, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    c = crc_model(4, 6);
    tx_q.push_back(c[7:0]);
    tx_q.push_back(c[15:8]);
    tx_q.push_back(8'h08);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    expect_packet(4, 1'b1);
    drive_burst(4, tx_q.size(), 4);
    total++;
    if (hq.size() + wq.size() + dq.size() != 0) begin
      bad++;
      $display("FAIL four_lane_pending got %0d need 0", hq.size() + wq.size() + dq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c;
    sel = 4;
    tx_q = '{8'hC5, 8'h34, 8'h12, 8'h00};
    expect_packet(4, 1'b1);
    drive_burst(4, tx_q.size(), 0);
    tx_q = '{8'h9E, 8'h05, 8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    c = crc_model(4, 5) ^ 16'h0001;
    tx_q.push_back(c[7:0]);
    tx_q.push_back(c[15:8]);
    expect_packet(4, 1'b1);
    drive_burst(4, tx_q.size(), 4);
    total++;
    if (hq.size() + wq.size() + dq.size() != 0) begin
      bad++;
      $display("FAIL back_to_back_pending got %0d need 0", hq.size() + wq.size() + dq.size());
    end
  endtask

  task automatic test_vc_filter();
    logic [15:0] c;
    sel = 2;
    tx_q = '{8'h58, 8'h08, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40,
             8'h50, 8'h60, 8'h70, 8'h80, 8'h12, 8'h34};
    expect_packet(2, 1'b0);
    drive_burst(2, tx_q.size(), 0);
    tx_q = '{8'h1A, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    c = crc_model(4, 4);
    tx_q.push_back(c[7:0]);
    tx_q.push_back(c[15:8]);
    tx_q.push_back(8'h08);
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h03);
    expect_packet(2, 1'b1);
    drive_burst(2, tx_q.size(), 4);
    total++;
    if (hq.size() + wq.size() + dq.size() != 0) begin
      bad++;
      $display("FAIL vc_filter_pending got %0d need 0", hq.size() + wq.size() + dq.size());
    end
  endtask

  task automatic test_abort();
    sel = 1;
    tx_q = '{8'h18, 8'h08, 8'h00, 8'h00, 8'hAD, 8'hDE, 8'hE1, 8'hFE};
    hq.push_back('{2'd0, 6'h18, 16'd8, 1'b0});
    abort_exp++;
    drive_burst(1, 7, 4);
    total++;
    if (abort_seen !== abort_exp) begin
      bad++;
      $display("FAIL abort_count got %0d need %0d", abort_seen, abort_exp);
    end else
      $display("abort ok count=%0d", abort_seen);
    tx_q = '{8'h4A, 8'h78, 8'h56, 8'h00};
    expect_packet(1, 1'b1);
    drive_burst(1, tx_q.size(), 4);
    total++;
    if (hq.size() + wq.size() + dq.size() != 0 || abort_seen !== abort_exp) begin
      bad++;
      $display("FAIL abort_pending got %0d/%0d need 0/%0d",
               hq.size() + wq.size() + dq.size(), abort_seen, abort_exp);
    end
  endtask

  task automatic test_reset_mid_packet();
    sel = 2;
    tx_q = '{8'h18, 8'h08, 8'h00, 8'hFE, 8'hAD, 8'hDE, 8'hE1, 8'hFE,
             8'h5E, 8'hEA, 8'h15, 8'h0D, 8'hD0, 8'hF0};
    hq.push_back('{2'd0, 6'h18, 16'd8, 1'b0});
    for (int c = 0; c < 7; c++) begin
      @(posedge clock); #1;
      if (c == 3) begin
        total++;
        if (m_bz !== 1'b1) begin
          bad++;
          $display("FAIL busy_mid_payload got %b need 1", m_bz);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_vc, m_dt, m_wc, m_hv, m_id, m_ik, m_ie, m_pd, m_pa, m_ce, m_bz} !== '0) begin
          bad++;
          $display("FAIL reset_mid_clear got %h need 0",
                   {m_vc, m_dt, m_wc, m_hv, m_id, m_ik, m_ie, m_pd, m_pa, m_ce, m_bz});
        end else
          $display("reset mid-payload ok");
      end
      if (c == 4) rst_n = 1'b1;
      put(2, {16'h0, tx_q[2*c+1], tx_q[2*c]}, 1'b1);
    end
    @(posedge clock); #1;
    put(2, 32'h0, 1'b0);
    repeat (3) @(posedge clock);
    total++;
    if (hq.size() + wq.size() + dq.size() != 0 || abort_seen !== abort_exp) begin
      bad++;
      $display("FAIL reset_mid_residue got %0d/%0d need 0/%0d",
               hq.size() + wq.size() + dq.size(), abort_seen, abort_exp);
    end
    tx_q = '{8'h01, 8'h34, 8'h12, 8'h00};
    expect_packet(2, 1'b1);
    drive_burst(2, tx_q.size(), 4);
    total++;
    if (hq.size() + wq.size() + dq.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_next_pending got %0d need 0", hq.size() + wq.size() + dq.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ld1 = '0; ld2 = '0; ld4 = '0;
    lv1 = 1'b0; lv2 = 1'b0; lv4 = 1'b0;
    test_reset();
    test_short_packet();
    test_long_packet();
    test_crc_vector();
    test_four_lane();
    test_back_to_back();
    test_vc_filter();
    test_abort();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csi2_packet_rx.md
# csi2_packet_rx

Parametrised CSI-2 packet receiver for 1, 2 or 4 data lanes. Sits after the per-lane sync detectors and byte aligners in the camera path. Merges lane bytes into the packet byte stream, parses the 32-bit packet header and filters by virtual channel. Emits payload as 32-bit words with byte-keep, and reports packet completion or abort, with an optional payload CRC check.

## Interface
Parameters:
- NUM_LANES, 2, lane count; legal values 1, 2, 4
- VC_MASK, 4'b1111, bit n set accepts virtual channel n; packets on other channels are consumed silently

Ports:
- clock  in  1  byte clock
- reset_n  in  1  asynchronous, active-low reset
- lane_data  in  8*NUM_LANES  lane i byte on [8*i+7:8*i]; sync byte already stripped
- lane_valid  in  1  all lanes carry a byte this cycle; high for the whole HS burst
- virtual_channel  out  2  VC of last accepted header
- data_type  out  6  DT of last accepted header
- word_count  out  16  WC of last accepted header (short packet: 16-bit data field)
- header_valid  out  1  one-cycle pulse: header fields updated
- image_data  out  32  payload word; first-received byte on [7:0]
- image_data_keep  out  4  valid bytes of image_data, contiguous from bit 0
- image_data_enable  out  1  one-cycle pulse: image_data/keep valid
- packet_done  out  1  one-cycle pulse: packet fully received
- packet_abort  out  1  one-cycle pulse: lane_valid dropped mid-packet
- crc_error  out  1  valid with packet_done; 1 = payload CRC mismatch
- busy  out  1  high in HEADER, PAYLOAD, CRC

## Operation
- Byte k of a burst is lane (k mod NUM_LANES), cycle (k / NUM_LANES).
- Header: byte0 = {VC[1:0], DT[5:0]}; byte1 = WC[7:0]; byte2 = WC[15:8]; byte3 = ECC, which is captured and ignored. DT ≤ 0x0F means short packet.
- One packet per HS burst. Bytes after packet end are ignored until lane_valid goes low.
- FSM states:
  - DRAIN: entered on reset and after packet end. Goes to IDLE on a cycle with lane_valid = 0.
  - IDLE: on lane_valid = 1, goes to HEADER, and this cycle's bytes count as header bytes.
  - HEADER: collects 4 bytes. On completion:
    - Short packet: goes to DRAIN with packet_done.
    - Long packet, WC = 0: goes to CRC.
    - Long packet, otherwise: goes to PAYLOAD.
  - PAYLOAD: packs bytes into a 4-byte accumulator. Emits a word with keep 4'hF on each fourth byte. The final partial word is emitted with keep = (1 << (WC mod 4)) - 1. When WC bytes are consumed, goes to CRC.
  - CRC: consumes 2 bytes, LSB first. Then goes to DRAIN with packet_done.
- A single cycle can span a state boundary (e.g. 4 lanes, WC = 6: bytes 4–5 are payload and bytes 6–7 are CRC). Each byte is routed by its position, not by cycle.
- Payload byte counter is 16 bits and compares against WC. There is no wrap: the maximum is 65535 payload bytes.
- Filtered VC (VC_MASK[vc] = 0):
  - Fields are not updated; header_valid, image_data_enable and packet_done stay 0.
  - Bytes are consumed through PAYLOAD/CRC exactly as for an accepted packet.
- lane_valid = 0 while busy:
  - packet_abort pulses and the partial word is discarded; packet_done does not pulse.
  - FSM goes to IDLE directly, because lane_valid is already low.
- Reset values: all outputs 0; FSM = DRAIN. Reset mid-packet discards everything, and the remainder of the burst is ignored.

## Timing
- All outputs are registered.
- header_valid and the field updates: the cycle after the edge that samples header byte3.
- image_data_enable: the cycle after the edge that samples the completing byte.
- packet_done and crc_error: the cycle after the edge that samples the last CRC byte (long packet) or byte3 (short packet).
- With 4 lanes the header is captured in 1 cycle; with 2 lanes, 2 cycles; with 1 lane, 4 cycles.
- Throughput: 1 word per 4/NUM_LANES cycles, with no back-pressure.
- If the final word and packet_done fall in the same sampled cycle, they assert together.

## Configuration
- CSI2_PACKET_RX_CRC_CHECK_EN defined:
  - CRC-16 with polynomial x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, no final XOR.
  - Computed over payload bytes only, processing up to NUM_LANES bytes per cycle.
  - crc_error = (computed ≠ received) at packet_done.
- Not defined: CRC logic is absent, CRC bytes are consumed unchecked, and crc_error is tied to 0.

## Test plan
- Short packet, 2 lanes, bytes 08 CE FA 12:
  - Response: header_valid with data_type 0x08, word_count 0xFACE, virtual_channel 0.
  - packet_done in the same cycle; no image_data_enable.
- Long packet, 2 lanes, bytes 18 08 00 FE AD DE E1 FE 5E EA 15 0D D0 F0:
  - Response: image_data 0xFEE1DEAD then 0x0D15EA5E, both with keep 4'hF.
  - packet_done; crc_error = 1 with the macro, 0 without.
- CRC vector, 1 lane:
  - Payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, followed by CRC bytes F0 00.
  - Response: 6 words and crc_error = 0.
- 4 lanes, WC = 6, payload 01..06:
  - Response: words 0x04030201 (keep 4'hF) and 0x00000605 (keep 4'b0011) on consecutive payload cycles, with packet_done together with the second word.
- VC_MASK = 4'b0001:
  - A packet with header byte0 0x58 (VC1, DT 0x18, WC 8) produces no output pulses.
  - The next burst with VC0 is accepted normally.
- Aborts:
  - lane_valid drops after 3 payload bytes: packet_abort pulses, with no image_data_enable and no packet_done.
  - reset_n asserted mid-payload: all outputs go to 0; the rest of the burst produces nothing; the next burst parses correctly.
